// File: rtl/mac_rr_scheduler_pkg.sv
// rtl/mac_rr_scheduler_pkg.sv - shared sizing, operand and result types for the shared MAC scheduler
package mac_rr_scheduler_pkg;

  localparam int N_REQ         = 4;
  localparam int SIZE_A        = 8;
  localparam int SIZE_B        = 8;
  localparam int SIZE_C        = 8;
  localparam int SIZE_DATA_OUT = 16;
  localparam int OUT_DEPTH     = 4;
  localparam int ID_W          = $clog2(N_REQ);

  localparam int FIFO_AW = $clog2(OUT_DEPTH);
  localparam int CNT_W   = FIFO_AW + 1;

  function automatic int max_int(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  // Wide enough that the sum never wraps before the final truncation to SIZE_DATA_OUT.
  localparam int SUM_W = max_int(max_int(SIZE_A + SIZE_B, SIZE_C), SIZE_DATA_OUT) + 1;

  typedef struct packed {
    logic [SIZE_A-1:0] a;
    logic [SIZE_B-1:0] b;
    logic [SIZE_C-1:0] c;
    logic [ID_W-1:0]   id;
  } mac_op_t;

  typedef struct packed {
    logic [SIZE_DATA_OUT-1:0] data;
    logic [ID_W-1:0]          id;
  } mac_res_t;

endpackage

// File: rtl/mac_rr_scheduler_mac_pipe.sv
// rtl/mac_rr_scheduler_mac_pipe.sv - two-stage unsigned A*B+C pipeline carrying the requester id and a valid bit
module mac_pipe
  import mac_rr_scheduler_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     in_valid,
  input  mac_op_t  in_op,
  output logic     out_valid,
  output mac_res_t out_res
);

  mac_op_t          s1_op;
  logic             s1_valid;
  logic [SUM_W-1:0] sum;

  assign sum = SUM_W'(s1_op.a) * SUM_W'(s1_op.b) + SUM_W'(s1_op.c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_op     <= '0;
      out_valid <= 1'b0;
      out_res   <= '0;
    end else begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
      if (in_valid) begin
        s1_op <= in_op;
      end
      if (s1_valid) begin
        out_res.data <= SIZE_DATA_OUT'(sum);
        out_res.id   <= s1_op.id;
      end
    end
  end

endmodule

// File: rtl/mac_rr_scheduler.sv
// rtl/mac_rr_scheduler.sv - round-robin sharing of one MAC pipeline with credit-gated issue into a tagged result FIFO
module mac_rr_scheduler
  import mac_rr_scheduler_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*SIZE_A-1:0]   req_a,
  input  logic [N_REQ*SIZE_B-1:0]   req_b,
  input  logic [N_REQ*SIZE_C-1:0]   req_c,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [SIZE_DATA_OUT-1:0]  res_data,
  output logic [ID_W-1:0]           res_id,
  output logic                      busy
);

  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    grant;
  logic [ID_W-1:0]    idx;
  logic               grant_found;
  logic               credit_ok;
  logic               accept;
  logic               push;
  logic               pop;
  logic [1:0]         inflight;
  mac_op_t            op;
  mac_res_t           pipe_res;
  mac_res_t           mem [OUT_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [CNT_W-1:0]   count;

  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    idx         = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ptr + ID_W'(k);
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant       = idx;
      end
    end
  end

  // Registered counts only: a pop this cycle frees its credit next cycle.
  assign credit_ok = ((CNT_W+1)'(inflight) + (CNT_W+1)'(count)) < (CNT_W+1)'(OUT_DEPTH);

  always_comb begin
    req_ready = '0;
    if (!reset && grant_found && credit_ok) begin
      req_ready[grant] = 1'b1;
    end
  end

  assign accept = |(req_valid & req_ready);

  always_comb begin
    op    = '0;
    op.a  = req_a[grant*SIZE_A +: SIZE_A];
    op.b  = req_b[grant*SIZE_B +: SIZE_B];
    op.c  = req_c[grant*SIZE_C +: SIZE_C];
    op.id = grant;
  end

  mac_pipe u_pipe (
    .clk       (clk),
    .rst       (reset),
    .in_valid  (accept),
    .in_op     (op),
    .out_valid (push),
    .out_res   (pipe_res)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr      <= '0;
      inflight <= '0;
    end else begin
      if (accept) begin
        ptr <= grant + ID_W'(1);
      end
      case ({accept, push})
        2'b10:   inflight <= inflight + 2'd1;
        2'b01:   inflight <= inflight - 2'd1;
        default: inflight <= inflight;
      endcase
    end
  end

  assign res_valid = (count != '0);
  assign pop       = res_valid && res_ready;
  assign res_data  = mem[rd_ptr].data;
  assign res_id    = mem[rd_ptr].id;
  assign busy      = (inflight != '0) || res_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= pipe_res;
        wr_ptr      <= wr_ptr + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  push_never_full: assert property (@(posedge clk) disable iff (reset)
    !(push && (count == CNT_W'(OUT_DEPTH))));

endmodule
